// File: rtl/wb_frame_capture_ctl.sv
// Multi-buffer camera capture sequencer behind a Wishbone register file; rotates
// NUM_BUF base addresses, gates the camera stream and measures frame period/lines.
module wb_frame_capture_ctl #(
  parameter int NUM_BUF     = 2,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [5:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        frame_start_i,
  input  logic        line_i,
  input  logic        capture_done_i,
  output logic        enable_o,
  output logic [31:0] buf_addr_o,
  output logic        buf_load_o,
  output logic        irq_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, CAPT = 2'd2, DRAIN = 2'd3} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] fs_sync, ln_sync;
  logic fs_prev, ln_prev, frame_edge, line_edge;
  logic wb_req, wr;
  logic [3:0] reg_adr;
  logic start, abort, w1c_ovr, w1c_done;
  logic start_evt, done_evt, ovr_evt, last_frame, load_set;
  logic irq_en, done, overrun;
  logic [2:0] idx, idx_nxt;
  logic [31:0] nframes, fcount, rd_dat;
  logic [31:0] buf_base [8];
  logic [CNT_W-1:0] period, period_cnt, lines, line_cnt;
  logic unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  function automatic logic [31:0] bmerge(input logic [31:0] cur, input logic [31:0] wd,
                                         input logic [3:0] sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = sel[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      fs_sync <= '0;
      ln_sync <= '0;
      fs_prev <= 1'b0;
      ln_prev <= 1'b0;
    end else begin
      fs_sync <= {fs_sync[SYNC_STAGES-2:0], frame_start_i};
      ln_sync <= {ln_sync[SYNC_STAGES-2:0], line_i};
      fs_prev <= fs_sync[SYNC_STAGES-1];
      ln_prev <= ln_sync[SYNC_STAGES-1];
    end
  end

  assign frame_edge = fs_sync[SYNC_STAGES-1] & ~fs_prev;
  assign line_edge  = ln_sync[SYNC_STAGES-1] & ~ln_prev;

  assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = wb_req & wb_we_i;
  assign reg_adr  = wb_adr_i[5:2];
  assign start    = wr && reg_adr == 4'd0 && wb_sel_i[0] && wb_dat_i[0];
  assign abort    = wr && reg_adr == 4'd0 && wb_sel_i[0] && wb_dat_i[1];
  assign w1c_ovr  = wr && reg_adr == 4'd1 && wb_sel_i[1] && wb_dat_i[8];
  assign w1c_done = wr && reg_adr == 4'd1 && wb_sel_i[1] && wb_dat_i[9];

  // Abort masks every other event in the same cycle.
  assign start_evt  = (state == IDLE) & start & ~abort;
  assign done_evt   = (state == DRAIN) & capture_done_i & ~abort;
  assign ovr_evt    = (state == DRAIN) & frame_edge & ~abort;
  assign last_frame = (nframes != 32'd0) && (fcount + 32'd1 == nframes);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (start) state_nxt = ARM;
        ARM:     if (frame_edge) state_nxt = CAPT;
        CAPT:    if (frame_edge) state_nxt = DRAIN;
        DRAIN:   if (capture_done_i) state_nxt = last_frame ? IDLE : ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    enable_o = (state == CAPT);
    load_set = (state_nxt == ARM) && (state != ARM);
  end

  always_comb begin
    idx_nxt = idx;
    if (start_evt)     idx_nxt = 3'd0;
    else if (done_evt) idx_nxt = (idx == 3'(NUM_BUF - 1)) ? 3'd0 : idx + 3'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx        <= '0;
      fcount     <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      buf_load_o <= 1'b0;
      buf_addr_o <= '0;
    end else begin
      idx        <= idx_nxt;
      buf_load_o <= load_set;
      if (load_set) buf_addr_o <= buf_base[idx_nxt];
      if (start_evt)     fcount <= '0;
      else if (done_evt) fcount <= fcount + 32'd1;
      if (done_evt)      done <= 1'b1;
      else if (w1c_done) done <= 1'b0;
      if (ovr_evt)       overrun <= 1'b1;
      else if (w1c_ovr)  overrun <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en  <= 1'b0;
      nframes <= '0;
      for (int i = 0; i < 8; i++) buf_base[i] <= '0;
    end else begin
      if (wr && reg_adr == 4'd0 && wb_sel_i[0]) irq_en <= wb_dat_i[3];
      if (wr && reg_adr == 4'd2) nframes <= bmerge(nframes, wb_dat_i, wb_sel_i);
      for (int i = 0; i < 8; i++)
        if (i < NUM_BUF && wr && reg_adr == 4'(8 + i))
          buf_base[i] <= bmerge(buf_base[i], wb_dat_i, wb_sel_i);
    end
  end

  // Period restarts at 1 so the latched value equals the edge spacing in cycles.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      period     <= '0;
      period_cnt <= '0;
      lines      <= '0;
      line_cnt   <= '0;
    end else begin
      if (frame_edge) begin
        period     <= period_cnt;
        period_cnt <= CNT_W'(1);
      end else if (period_cnt != CNT_MAX) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
      if (state != CAPT) line_cnt <= '0;
      else if (line_edge && line_cnt != CNT_MAX) line_cnt <= line_cnt + CNT_W'(1);
      if (state == CAPT && frame_edge && !abort) lines <= line_cnt;
    end
  end

  always_comb begin
    rd_dat = '0;
    case (reg_adr)
      4'd0: rd_dat = {28'd0, irq_en, 3'd0};
      4'd1: rd_dat = {22'd0, done, overrun, 1'b0, idx, 2'b00, state};
      4'd2: rd_dat = nframes;
      4'd3: rd_dat = fcount;
      4'd4: rd_dat = 32'(period);
      4'd5: rd_dat = 32'(lines);
      default: if (reg_adr[3] && int'(reg_adr[2:0]) < NUM_BUF) rd_dat = buf_base[reg_adr[2:0]];
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_req;
      if (wb_req) wb_dat_o <= wb_we_i ? 32'd0 : rd_dat;
    end
  end

  assign irq_o = irq_en & (done | overrun);

endmodule

// File: tb/tb_wb_frame_capture_ctl.sv
// Self-checking bench for wb_frame_capture_ctl: per-feature tasks plus a
// scoreboard of expected buffer-load addresses popped on every buf_load_o.
module tb_wb_frame_capture_ctl;
  localparam int NB = 3;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [5:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        frame_start_i = 1'b0, line_i = 1'b0, capture_done_i = 1'b0;
  logic        enable_o, buf_load_o, irq_o;
  logic [31:0] buf_addr_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] base_tb [NB] = '{32'h1000, 32'h2000, 32'h3000};

  always #5 wb_clk_i = ~wb_clk_i;

  wb_frame_capture_ctl #(.NUM_BUF(NB), .CNT_W(24), .SYNC_STAGES(2)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .frame_start_i(frame_start_i),
    .line_i(line_i), .capture_done_i(capture_done_i), .enable_o(enable_o),
    .buf_addr_o(buf_addr_o), .buf_load_o(buf_load_o), .irq_o(irq_o)
  );

  // Scoreboard: every load pulse must match the next expected base address.
  always @(negedge wb_clk_i) begin
    if (buf_load_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL buf_load_unexpected: addr %h, no load expected", buf_addr_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (buf_addr_o !== mon_exp) begin
          n_bad++;
          $display("FAIL buf_load_addr: got %h want %h", buf_addr_o, mon_exp);
        end
      end
    end
  end

  task automatic wait_ack();
    int n;
    n = 0;
    do begin
      @(posedge wb_clk_i); #1;
      n++;
    end while (wb_ack_o !== 1'b1 && n < 8);
    if (wb_ack_o !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wb_ack_timeout: ack %b after %0d cycles, want 1", wb_ack_o, n);
    end
  endtask

  task automatic wb_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wait_ack();
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic wb_read(input logic [5:0] a, output logic [31:0] d);
    wb_adr_i = a; wb_sel_i = 4'hF;
    wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wait_ack();
    d = wb_dat_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
  endtask

  // One camera frame: frame marker at cycle 0, nlines line pulses every 10 cycles
  // from cycle 20, optional capture_done pulse at cycle 10.
  task automatic run_frame(input int cycles, input int nlines, input bit send_done);
    for (int c = 0; c < cycles; c++) begin
      frame_start_i  = (c < 4);
      line_i         = (c >= 20) && (c < 20 + 10 * nlines) && (((c - 20) % 10) < 2);
      capture_done_i = send_done && (c == 10);
      @(posedge wb_clk_i); #1;
    end
    frame_start_i = 1'b0; line_i = 1'b0; capture_done_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_cmp++;
    if ({enable_o, buf_load_o, irq_o, wb_ack_o} !== 4'b0 || buf_addr_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: en/load/irq/ack %b%b%b%b addr %h, want all 0",
               enable_o, buf_load_o, irq_o, wb_ack_o, buf_addr_o);
    end
    for (int a = 0; a <= 10; a++) begin
      wb_read(6'(a * 4), rd);
      n_cmp++;
      if (rd !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_reg_%0h: got %h want 0", a * 4, rd);
      end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    wb_write(6'h24, 32'hAABBCCDD, 4'b0101);
    wb_read(6'h24, rd);
    n_cmp++;
    if (rd !== 32'h00BB00DD) begin
      n_bad++; $display("FAIL byte_sel_a: got %h want 00bb00dd", rd);
    end
    wb_write(6'h24, 32'h11223344, 4'b1010);
    wb_read(6'h24, rd);
    n_cmp++;
    if (rd !== 32'h11BB33DD) begin
      n_bad++; $display("FAIL byte_sel_b: got %h want 11bb33dd", rd);
    end
    wb_write(6'h18, 32'hDEADBEEF, 4'hF);
    wb_read(6'h18, rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_bad++; $display("FAIL unmapped_0x18: got %h want 0", rd);
    end
    wb_write(6'h2C, 32'hDEADBEEF, 4'hF);
    wb_read(6'h2C, rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_bad++; $display("FAIL base_beyond_num_buf: got %h want 0", rd);
    end
    wb_write(6'h0C, 32'h55, 4'hF);
    wb_read(6'h0C, rd);
    n_cmp++;
    if (rd !== 32'd0) begin
      n_bad++; $display("FAIL fcount_read_only: got %h want 0", rd);
    end
    wb_write(6'h00, 32'h8, 4'hF);
    wb_read(6'h00, rd);
    n_cmp++;
    if (rd !== 32'h8) begin
      n_bad++; $display("FAIL ctrl_irq_en: got %h want 8", rd);
    end
    wb_write(6'h00, 32'h0, 4'hF);
    for (int i = 0; i < NB; i++) wb_write(6'(32 + 4 * i), base_tb[i], 4'hF);
    wb_read(6'h28, rd);
    n_cmp++;
    if (rd !== base_tb[2]) begin
      n_bad++; $display("FAIL base2_readback: got %h want %h", rd, base_tb[2]);
    end
  endtask

  task automatic test_multi_frame();
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) exp_q.push_back(base_tb[i % NB]);
    wb_write(6'h08, 32'd3, 4'hF);
    wb_write(6'h00, 32'h1, 4'hF);
    for (int f = 0; f < 6; f++) run_frame(200, 5, 1'b1);
    wb_read(6'h0C, rd);
    n_cmp++;
    if (rd !== 32'd3) begin
      n_bad++; $display("FAIL multi_fcount: got %0d want 3", rd);
    end
    wb_read(6'h14, rd);
    n_cmp++;
    if (rd !== 32'd5) begin
      n_bad++; $display("FAIL multi_lines: got %0d want 5", rd);
    end
    run_frame(200, 5, 1'b1);
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h200) begin
      n_bad++; $display("FAIL multi_stat_idle_done: got %h want 200", rd);
    end
    n_cmp++;
    if (exp_q.size() != 0 || irq_o !== 1'b0) begin
      n_bad++; $display("FAIL multi_loads_irq: pending %0d irq %b, want 0 and 0", exp_q.size(), irq_o);
    end
    wb_write(6'h04, 32'h200, 4'b0010);
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h0) begin
      n_bad++; $display("FAIL done_w1c: got %h want 0", rd);
    end
  endtask

  task automatic test_period_lines();
    logic [31:0] rd;
    exp_q.push_back(base_tb[0]);
    exp_q.push_back(base_tb[1]);
    wb_write(6'h08, 32'd0, 4'hF);
    wb_write(6'h00, 32'h1, 4'hF);
    for (int f = 0; f < 3; f++) run_frame(5000, 480, 1'b1);
    wb_read(6'h10, rd);
    n_cmp++;
    if (rd !== 32'd5000) begin
      n_bad++; $display("FAIL period: got %0d want 5000", rd);
    end
    wb_read(6'h14, rd);
    n_cmp++;
    if (rd !== 32'd480) begin
      n_bad++; $display("FAIL lines: got %0d want 480", rd);
    end
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h212 || enable_o !== 1'b1) begin
      n_bad++; $display("FAIL capt_stat: stat %h enable %b, want 212 and 1", rd, enable_o);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL period_loads_missing: %0d pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    wb_adr_i = 6'h00; wb_dat_i = 32'h2; wb_sel_i = 4'h1;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if (enable_o !== 1'b0 || wb_ack_o !== 1'b1) begin
      n_bad++; $display("FAIL abort_enable: enable %b ack %b, want 0 and 1", enable_o, wb_ack_o);
    end
    wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h210) begin
      n_bad++; $display("FAIL abort_stat: got %h want 210", rd);
    end
    wb_read(6'h0C, rd);
    n_cmp++;
    if (rd !== 32'd1) begin
      n_bad++; $display("FAIL abort_fcount: got %0d want 1", rd);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    wb_write(6'h00, 32'h8, 4'hF);
    wb_write(6'h04, 32'h300, 4'b0010);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_bad++; $display("FAIL irq_cleared: got %b want 0", irq_o);
    end
    exp_q.push_back(base_tb[0]);
    wb_write(6'h00, 32'h9, 4'hF);
    for (int f = 0; f < 3; f++) run_frame(200, 5, 1'b0);
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h103 || irq_o !== 1'b1) begin
      n_bad++; $display("FAIL overrun_set: stat %h irq %b, want 103 and 1", rd, irq_o);
    end
    wb_write(6'h04, 32'h100, 4'b0010);
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h003 || irq_o !== 1'b0) begin
      n_bad++; $display("FAIL overrun_w1c: stat %h irq %b, want 003 and 0", rd, irq_o);
    end
    exp_q.push_back(base_tb[1]);
    capture_done_i = 1'b1;
    @(posedge wb_clk_i); #1;
    capture_done_i = 1'b0;
    repeat (2) begin @(posedge wb_clk_i); #1; end
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h211 || irq_o !== 1'b1) begin
      n_bad++; $display("FAIL irq_follows_done: stat %h irq %b, want 211 and 1", rd, irq_o);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL overrun_loads_missing: %0d pending, want 0", exp_q.size());
    end
    wb_write(6'h00, 32'h2, 4'hF);
  endtask

  task automatic test_rotation();
    logic [31:0] rd;
    wb_write(6'h04, 32'h300, 4'b0010);
    for (int i = 0; i <= 10; i++) exp_q.push_back(base_tb[i % NB]);
    wb_write(6'h00, 32'h1, 4'hF);
    for (int f = 0; f < 20; f++) run_frame(200, 5, 1'b1);
    wb_read(6'h04, rd);
    n_cmp++;
    if (rd !== 32'h211) begin
      n_bad++; $display("FAIL rotation_stat: got %h want 211", rd);
    end
    wb_read(6'h0C, rd);
    n_cmp++;
    if (rd !== 32'd10) begin
      n_bad++; $display("FAIL rotation_fcount: got %0d want 10", rd);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL rotation_loads_missing: %0d pending, want 0", exp_q.size());
    end
    wb_write(6'h00, 32'h2, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    wb_write(6'h08, 32'd7, 4'hF);
    exp_q.push_back(base_tb[0]);
    wb_write(6'h00, 32'h1, 4'hF);
    run_frame(200, 5, 1'b0);
    n_cmp++;
    if (enable_o !== 1'b1) begin
      n_bad++; $display("FAIL mid_capt_enable: got %b want 1", enable_o);
    end
    #3 wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({enable_o, buf_load_o, irq_o} !== 3'b0 || buf_addr_o !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset_outputs: en/load/irq %b%b%b addr %h, want all 0",
               enable_o, buf_load_o, irq_o, buf_addr_o);
    end
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    for (int a = 0; a <= 10; a++) begin
      wb_read(6'(a * 4), rd);
      n_cmp++;
      if (rd !== 32'd0) begin
        n_bad++; $display("FAIL post_reset_reg_%0h: got %h want 0", a * 4, rd);
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL reset_loads_missing: %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    test_reset();
    test_regs();
    test_multi_frame();
    test_period_lines();
    test_abort();
    test_overrun();
    test_rotation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
